// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to CDB_PORTS of NUM_FU pending FU results per
// cycle in rotating round-robin order and registers the winners onto the CDB.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int CDB_PORTS  = 2,
  parameter int PHYS_WIDTH = 6,
  parameter int ROB_WIDTH  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU*PHYS_WIDTH-1:0]    fu_pd,
  input  logic [NUM_FU*32-1:0]            fu_data,
  input  logic [NUM_FU*ROB_WIDTH-1:0]     fu_rob_idx,
  output logic [NUM_FU-1:0]               fu_ready,
  output logic [CDB_PORTS-1:0]            cdb_valid,
  output logic [CDB_PORTS*PHYS_WIDTH-1:0] cdb_pd,
  output logic [CDB_PORTS*32-1:0]         cdb_data,
  output logic [CDB_PORTS*ROB_WIDTH-1:0]  cdb_rob_idx,
  output logic [CDB_PORTS-1:0]            pregf_we
);

  localparam int          PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned NF    = NUM_FU;
  localparam int unsigned CP    = CDB_PORTS;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     next_ptr;
  logic [CDB_PORTS-1:0] port_hit;
  logic [PTR_W-1:0]     port_sel [CDB_PORTS];

  // Scan from rr_ptr with wraparound; the j-th winner in scan order takes port j.
  always_comb begin
    int unsigned cnt;
    int unsigned idx;
    fu_ready = '0;
    port_hit = '0;
    next_ptr = rr_ptr;
    cnt      = 0;
    idx      = 0;
    for (int unsigned k = 0; k < CP; k++) port_sel[k] = '0;
    for (int unsigned s = 0; s < NF; s++) begin
      idx = 32'(rr_ptr) + s;
      if (idx >= NF) idx = idx - NF;
      if (!rst && !flush && fu_valid[idx] && cnt < CP) begin
        fu_ready[idx] = 1'b1;
        port_hit[cnt] = 1'b1;
        port_sel[cnt] = PTR_W'(idx);
        next_ptr      = (idx + 1 == NF) ? '0 : PTR_W'(idx + 1);
        cnt           = cnt + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      cdb_valid   <= '0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
    end else begin
      // flush already suppresses every grant, so this also squashes the bus
      cdb_valid <= port_hit;
      rr_ptr    <= next_ptr;
      for (int unsigned k = 0; k < CP; k++) begin
        if (port_hit[k]) begin
          cdb_pd[k*PHYS_WIDTH +: PHYS_WIDTH]   <= fu_pd[port_sel[k]*PHYS_WIDTH +: PHYS_WIDTH];
          cdb_data[k*32 +: 32]                 <= fu_data[port_sel[k]*32 +: 32];
          cdb_rob_idx[k*ROB_WIDTH +: ROB_WIDTH] <= fu_rob_idx[port_sel[k]*ROB_WIDTH +: ROB_WIDTH];
        end
      end
    end
  end

  // x0 results still broadcast for ROB completion but never write the PRF
  always_comb begin
    pregf_we = '0;
    for (int unsigned k = 0; k < CP; k++)
      pregf_we[k] = cdb_valid[k] && (cdb_pd[k*PHYS_WIDTH +: PHYS_WIDTH] != '0);
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int CP = 2;
  localparam int PW = 6;
  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NF-1:0]     fu_valid;
  logic [NF*PW-1:0]  fu_pd;
  logic [NF*32-1:0]  fu_data;
  logic [NF*RW-1:0]  fu_rob_idx;
  logic [NF-1:0]     fu_ready;
  logic [CP-1:0]     cdb_valid;
  logic [CP*PW-1:0]  cdb_pd;
  logic [CP*32-1:0]  cdb_data;
  logic [CP*RW-1:0]  cdb_rob_idx;
  logic [CP-1:0]     pregf_we;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_FU(NF), .CDB_PORTS(CP), .PHYS_WIDTH(PW), .ROB_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_pd(fu_pd), .fu_data(fu_data), .fu_rob_idx(fu_rob_idx),
    .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_data(cdb_data), .cdb_rob_idx(cdb_rob_idx),
    .pregf_we(pregf_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // j-th valid FU found walking around the ring from ptr, or -1 if fewer exist
  function automatic int winner(input int ptr, input logic [NF-1:0] v, input int j);
    int seen = 0;
    for (int s = 0; s < NF; s++) begin
      int f = (ptr + s) % NF;
      if (v[f]) begin
        if (seen == j) return f;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic logic [NF-1:0] grant_mask(input int ptr, input logic [NF-1:0] v, input bit blk);
    logic [NF-1:0] m = '0;
    if (!blk)
      for (int j = 0; j < CP; j++)
        if (winner(ptr, v, j) >= 0) m[winner(ptr, v, j)] = 1'b1;
    return m;
  endfunction

  function automatic int last_win(input int ptr, input logic [NF-1:0] v);
    int last = -1;
    for (int j = 0; j < CP; j++)
      if (winner(ptr, v, j) >= 0) last = winner(ptr, v, j);
    return last;
  endfunction

  int             m_ptr;
  logic [CP-1:0]  m_valid;
  logic [PW-1:0]  m_pd   [CP];
  logic [31:0]    m_data [CP];
  logic [RW-1:0]  m_rob  [CP];
  logic [NF-1:0]  last_grant = '0;
  bit             started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_ptr      <= 0;
      m_valid    <= '0;
      last_grant <= '0;
    end else begin
      last_grant <= grant_mask(m_ptr, fu_valid, flush);
      for (int j = 0; j < CP; j++) begin
        if (!flush && winner(m_ptr, fu_valid, j) >= 0) begin
          m_valid[j] <= 1'b1;
          m_pd[j]    <= fu_pd[winner(m_ptr, fu_valid, j)*PW +: PW];
          m_data[j]  <= fu_data[winner(m_ptr, fu_valid, j)*32 +: 32];
          m_rob[j]   <= fu_rob_idx[winner(m_ptr, fu_valid, j)*RW +: RW];
        end else begin
          m_valid[j] <= 1'b0;
        end
      end
      if (!flush && last_win(m_ptr, fu_valid) >= 0)
        m_ptr <= (last_win(m_ptr, fu_valid) + 1) % NF;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("fu_ready", fu_ready, grant_mask(m_ptr, fu_valid, rst || flush));
      chk("rr_ptr", dut.rr_ptr, m_ptr);
      for (int k = 0; k < CP; k++) begin
        chk("cdb_valid", cdb_valid[k], m_valid[k]);
        chk("pregf_we", pregf_we[k], m_valid[k] && (m_pd[k] != '0));
        if (m_valid[k]) begin
          chk("cdb_pd", cdb_pd[k*PW +: PW], m_pd[k]);
          chk("cdb_data", cdb_data[k*32 +: 32], m_data[k]);
          chk("cdb_rob_idx", cdb_rob_idx[k*RW +: RW], m_rob[k]);
        end
      end
      for (int a = 0; a < NF; a++)
        for (int b = a + 1; b < NF; b++)
          assert (!(fu_valid[a] && fu_valid[b] && fu_pd[a*PW +: PW] == fu_pd[b*PW +: PW]))
            else $error("two valid FUs share a destination pd");
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [PW-1:0] pd,
                        input logic [31:0] d, input logic [RW-1:0] r);
    fu_valid[i]          = v;
    fu_pd[i*PW +: PW]    = pd;
    fu_data[i*32 +: 32]  = d;
    fu_rob_idx[i*RW +: RW] = r;
  endtask

  task automatic rand_inputs(input int dense);
    rst   = ($urandom_range(0, 299) == 0);
    flush = ($urandom_range(0, 9) == 0);
    for (int i = 0; i < NF; i++) begin
      // a pending result stays put until it has actually transferred
      if (!(fu_valid[i] && !last_grant[i]))
        set_fu(i, ($urandom_range(0, 99) < dense),
               {4'($urandom_range(0, 15)), 2'(i)}, $urandom, RW'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < NF; i++) set_fu(i, 1'b1, PW'(i + 1), 32'h100 + i, RW'(i));
    #2;
    chk("rst_ready", fu_ready, 4'b0000);
    step(); step(); step();
    rst = 1'b0;
    #2;
    chk("post_rst_valid", cdb_valid, 2'b00);
    chk("post_rst_ready", fu_ready, 4'b0011);

    // all FUs requesting: {0,1}, {2,3}, {0,1}
    step(); #2;
    chk("rr_ready_23", fu_ready, 4'b1100);
    chk("rr_valid", cdb_valid, 2'b11);
    chk("rr_pd_p0", cdb_pd[0 +: PW], 6'h01);
    chk("rr_pd_p1", cdb_pd[PW +: PW], 6'h02);
    step(); #2;
    chk("rr_ready_01", fu_ready, 4'b0011);
    chk("rr_ptr_0", dut.rr_ptr, 2'd0);
    chk("rr_pd2_p0", cdb_pd[0 +: PW], 6'h03);
    chk("rr_pd2_p1", cdb_pd[PW +: PW], 6'h04);

    // steer rr_ptr to 3, then sparse wrap with FU1 and FU3
    step();
    fu_valid = 4'b0100;
    #2 chk("steer_ready", fu_ready, 4'b0100);
    step();
    set_fu(3, 1'b1, 6'h15, 32'hDEADBEEF, 5'd3);
    set_fu(1, 1'b1, 6'h0A, 32'h11112222, 5'd1);
    fu_valid = 4'b1010;
    #2 chk("wrap_ready", fu_ready, 4'b1010);
    step();
    set_fu(2, 1'b1, 6'h00, 32'h0000CAFE, 5'd7);
    fu_valid = 4'b0100;
    #2;
    chk("wrap_valid", cdb_valid, 2'b11);
    chk("wrap_pd_p0", cdb_pd[0 +: PW], 6'h15);
    chk("wrap_data_p0", cdb_data[0 +: 32], 32'hDEADBEEF);
    chk("wrap_pd_p1", cdb_pd[PW +: PW], 6'h0A);
    chk("wrap_data_p1", cdb_data[32 +: 32], 32'h11112222);
    chk("wrap_ptr", dut.rr_ptr, 2'd2);
    chk("x0_ready", fu_ready, 4'b0100);

    // x0 result broadcast without PRF write; then FU0 granted in cycle N-1
    step();
    fu_valid = 4'b0001;
    #2;
    chk("x0_valid", cdb_valid, 2'b01);
    chk("x0_rob", cdb_rob_idx[0 +: RW], 5'd7);
    chk("x0_we", pregf_we, 2'b00);
    chk("pre_flush_ready", fu_ready, 4'b0001);

    // cycle N: flush with FU1 requesting
    step();
    flush = 1'b1;
    fu_valid = 4'b0010;
    #2;
    chk("flush_ready", fu_ready, 4'b0000);
    chk("flush_inflight", cdb_valid, 2'b01);
    step();
    flush = 1'b0;
    #2;
    chk("flush_squash", cdb_valid, 2'b00);
    chk("post_flush_ready", fu_ready, 4'b0010);
    chk("flush_ptr", dut.rr_ptr, 2'd1);

    // single requester streaming on FU1
    step();
    for (int i = 0; i < 5; i++) begin
      set_fu(1, 1'b1, 6'h0A, 32'h1000 + i, 5'd1);
      #2;
      chk("stream_ready", fu_ready, 4'b0010);
      chk("stream_ptr", dut.rr_ptr, 2'd2);
      chk("stream_valid", cdb_valid, 2'b01);
      if (i > 0) chk("stream_data", cdb_data[0 +: 32], 32'h1000 + i - 1);
      else       chk("post_flush_pd", cdb_pd[0 +: PW], 6'h0A);
      step();
    end
    fu_valid = '0;
    #2;
    chk("stream_last", cdb_data[0 +: 32], 32'h1004);
    chk("stream_last_valid", cdb_valid, 2'b01);

    // randomized traffic, alternating sparse and dense phases
    for (int c = 0; c < 3000; c++) begin
      step();
      rand_inputs(((c / 500) % 2) != 0 ? 90 : 35);
    end
    step();
    rst = 1'b0;
    flush = 1'b0;
    fu_valid = '0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
